llc_port_arbiter: RTL and testbench

Round-robin arbiter that shares the single upper-cache port of last_level_cache among NUM_REQ upper-level caches (requester 0 = L1D, requester 1 = L1I).
- Grants one line-granular request at a time and holds it stable until the LLC accepts it.
- Records the owner of every issued transaction in an in-order tracking FIFO.
- Routes each LLC response back to its owner.
- Sits between the L1 caches and the llc instance inside memory_subsystem.

---
 rtl/llc_port_arbiter.sv | 174 +++++++++++++++++
 tb/tb_llc_port_arbiter.sv | 511 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/llc_port_arbiter.sv
// Round-robin arbiter sharing the LLC upper port among NUM_REQ L1 caches.
// An in-order owner FIFO steers each LLC response back to its requester.
module llc_port_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned B               = 64,
    parameter int unsigned PADDR_BITS      = 19,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_N_in,
    input  logic                          cs_N_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    input  logic [NUM_REQ-1:0]            req_we_in,
    input  logic [NUM_REQ*PADDR_BITS-1:0] req_addr_in,
    input  logic [NUM_REQ*8*B-1:0]        req_value_in,
    output logic [NUM_REQ-1:0]            rsp_valid_out,
    input  logic [NUM_REQ-1:0]            rsp_ready_in,
    output logic [PADDR_BITS-1:0]         rsp_addr_out,
    output logic [8*B-1:0]                rsp_value_out,
    output logic                          lc_valid_out,
    input  logic                          lc_ready_in,
    output logic [PADDR_BITS-1:0]         lc_addr_out,
    output logic [8*B-1:0]                lc_value_out,
    output logic                          lc_we_out,
    input  logic                          lc_valid_in,
    output logic                          lc_ready_out,
    input  logic [PADDR_BITS-1:0]         lc_addr_in,
    input  logic [8*B-1:0]                lc_value_in,
    output logic                          err_unexpected_rsp_out
);
    localparam int unsigned LINE_W = 8 * B;
    localparam int unsigned IDX_W  = $clog2(NUM_REQ);
    localparam int unsigned PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic {
        ARB  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [IDX_W-1:0]      hold_idx;

    logic [IDX_W-1:0]      fifo_mem [MAX_OUTSTANDING];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    int unsigned           cand;
    logic                  grant_found;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant;
    logic [PADDR_BITS-1:0] sel_addr;
    logic [LINE_W-1:0]     sel_value;
    logic                  sel_we;
    logic [IDX_W-1:0]      head;
    logic                  nonempty;
    logic                  pop;

    // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!grant_found && req_valid_in[IDX_W'(cand)]) begin
                grant_found = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end

    // Payload of the selected requester
    always_comb begin
        sel_addr  = '0;
        sel_value = '0;
        sel_we    = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == grant_idx) begin
                sel_addr  = req_addr_in[i*PADDR_BITS +: PADDR_BITS];
                sel_value = req_value_in[i*LINE_W +: LINE_W];
                sel_we    = req_we_in[i];
            end
        end
    end

    // Grants are suppressed while reset is asserted so every output reads zero
    assign grant = rst_N_in && (state == ARB) && !cs_N_in &&
                   (count < CNT_W'(MAX_OUTSTANDING)) && grant_found;

    assign req_ready_out = grant ? (NUM_REQ'(1) << grant_idx) : '0;

    assign head          = fifo_mem[rd_ptr];
    assign nonempty      = (count != '0);
    assign rsp_valid_out = (lc_valid_in && nonempty) ? (NUM_REQ'(1) << head) : '0;
    assign lc_ready_out  = nonempty && rsp_ready_in[head];
    assign rsp_addr_out  = lc_addr_in;
    assign rsp_value_out = lc_value_in;
    assign pop           = lc_valid_in && lc_ready_out;

    // Request FSM: latch the winner, hold it until the LLC accepts
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state        <= ARB;
            rr_ptr       <= '0;
            hold_idx     <= '0;
            lc_valid_out <= 1'b0;
            lc_addr_out  <= '0;
            lc_value_out <= '0;
            lc_we_out    <= 1'b0;
        end else begin
            case (state)
                ARB: begin
                    if (grant) begin
                        state        <= HOLD;
                        hold_idx     <= grant_idx;
                        lc_valid_out <= 1'b1;
                        lc_addr_out  <= sel_addr;
                        lc_value_out <= sel_value;
                        lc_we_out    <= sel_we;
                    end
                end
                HOLD: begin
                    if (lc_ready_in) begin
                        state        <= ARB;
                        lc_valid_out <= 1'b0;
                        rr_ptr       <= (hold_idx == IDX_W'(NUM_REQ - 1)) ?
                                        '0 : hold_idx + IDX_W'(1);
                    end
                end
                default: begin
                    state        <= ARB;
                    lc_valid_out <= 1'b0;
                end
            endcase
        end
    end

    // Owner tracking FIFO and sticky unexpected-response flag
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            wr_ptr                 <= '0;
            rd_ptr                 <= '0;
            count                  <= '0;
            err_unexpected_rsp_out <= 1'b0;
            for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (grant) begin
                fifo_mem[wr_ptr] <= grant_idx;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (grant && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !grant) begin
                count <= count - CNT_W'(1);
            end
            if (lc_valid_in && !nonempty) begin
                err_unexpected_rsp_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_llc_port_arbiter.sv
// Bench for llc_port_arbiter: directed scenarios plus a randomized run
// against a queue-based reference model of arbitration and response routing.
`timescale 1ns/1ps
module tb_llc_port_arbiter;
    localparam int unsigned NR = 2;
    localparam int unsigned B  = 64;
    localparam int unsigned PA = 19;
    localparam int unsigned MO = 4;
    localparam int unsigned LW = 8 * B;
    localparam int unsigned IW = $clog2(NR);

    logic              clk_in = 1'b0;
    logic              rst_N_in;
    logic              cs_N_in;
    logic [NR-1:0]     req_valid_in;
    logic [NR-1:0]     req_ready_out;
    logic [NR-1:0]     req_we_in;
    logic [NR*PA-1:0]  req_addr_in;
    logic [NR*LW-1:0]  req_value_in;
    logic [NR-1:0]     rsp_valid_out;
    logic [NR-1:0]     rsp_ready_in;
    logic [PA-1:0]     rsp_addr_out;
    logic [LW-1:0]     rsp_value_out;
    logic              lc_valid_out;
    logic              lc_ready_in;
    logic [PA-1:0]     lc_addr_out;
    logic [LW-1:0]     lc_value_out;
    logic              lc_we_out;
    logic              lc_valid_in;
    logic              lc_ready_out;
    logic [PA-1:0]     lc_addr_in;
    logic [LW-1:0]     lc_value_in;
    logic              err_unexpected_rsp_out;

    logic              r_valid [NR];
    logic              r_we    [NR];
    logic [PA-1:0]     r_addr  [NR];
    logic [LW-1:0]     r_val   [NR];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar gi = 0; gi < NR; gi++) begin : g_pack
        assign req_valid_in[gi]             = r_valid[gi];
        assign req_we_in[gi]                = r_we[gi];
        assign req_addr_in[gi*PA +: PA]     = r_addr[gi];
        assign req_value_in[gi*LW +: LW]    = r_val[gi];
    end

    llc_port_arbiter #(
        .NUM_REQ(NR), .B(B), .PADDR_BITS(PA), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_in(clk_in), .rst_N_in(rst_N_in), .cs_N_in(cs_N_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_we_in(req_we_in), .req_addr_in(req_addr_in), .req_value_in(req_value_in),
        .rsp_valid_out(rsp_valid_out), .rsp_ready_in(rsp_ready_in),
        .rsp_addr_out(rsp_addr_out), .rsp_value_out(rsp_value_out),
        .lc_valid_out(lc_valid_out), .lc_ready_in(lc_ready_in),
        .lc_addr_out(lc_addr_out), .lc_value_out(lc_value_out), .lc_we_out(lc_we_out),
        .lc_valid_in(lc_valid_in), .lc_ready_out(lc_ready_out),
        .lc_addr_in(lc_addr_in), .lc_value_in(lc_value_in),
        .err_unexpected_rsp_out(err_unexpected_rsp_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [NR-1:0] oh(input int i);
        return NR'(1) << i;
    endfunction

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] v;
        v = '0;
        for (int i = 0; i < int'(LW / 32); i++) v[i*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic idle_inputs();
        cs_N_in      = 1'b0;
        rsp_ready_in = '0;
        lc_ready_in  = 1'b0;
        lc_valid_in  = 1'b0;
        lc_addr_in   = '0;
        lc_value_in  = '0;
        for (int i = 0; i < int'(NR); i++) begin
            r_valid[i] = 1'b0;
            r_we[i]    = 1'b0;
            r_addr[i]  = '0;
            r_val[i]   = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_N_in = 1'b0;
        idle_inputs();
        @(negedge clk_in);
        @(negedge clk_in);
        rst_N_in = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_N_in   = 1'b0;
        r_valid[0] = 1'b1;
        r_valid[1] = 1'b1;
        @(negedge clk_in); #1;
        n_tests++;
        if (req_ready_out !== '0) begin
            n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready_out);
        end
        n_tests++;
        if ({lc_valid_out, lc_we_out, lc_ready_out, err_unexpected_rsp_out, rsp_valid_out} !== '0) begin
            n_fail++; $display("FAIL reset_ctrl: lc_valid=%b we=%b lc_ready=%b err=%b rsp_valid=%b expected all 0",
                               lc_valid_out, lc_we_out, lc_ready_out, err_unexpected_rsp_out, rsp_valid_out);
        end
        n_tests++;
        if (lc_addr_out !== '0 || lc_value_out !== '0) begin
            n_fail++; $display("FAIL reset_data: lc_addr=%h lc_value=%h expected 0", lc_addr_out, lc_value_out);
        end
        @(negedge clk_in);
        rst_N_in = 1'b1;
        idle_inputs();
        @(negedge clk_in); #1;
        n_tests++;
        if ({lc_valid_out, req_ready_out, rsp_valid_out, err_unexpected_rsp_out} !== '0) begin
            n_fail++; $display("FAIL reset_release: lc_valid=%b req_ready=%b rsp_valid=%b err=%b expected all 0",
                               lc_valid_out, req_ready_out, rsp_valid_out, err_unexpected_rsp_out);
        end
    endtask

    task automatic test_fairness();
        logic [PA-1:0] lq_addr[$];
        int            lq_due[$];
        logic [PA-1:0] pend_addr;
        int            n_gnt;
        int            n_rsp;
        int            cyc;
        n_gnt = 0; n_rsp = 0; cyc = 0; pend_addr = '0;
        do_reset();
        rsp_ready_in = '1;
        lc_ready_in  = 1'b1;
        while (n_rsp < 4 && cyc < 80) begin
            @(negedge clk_in);
            cyc++;
            for (int i = 0; i < int'(NR); i++) begin
                r_valid[i] = (n_gnt < 4);
                r_addr[i]  = PA'($urandom);
            end
            lc_valid_in = 1'b0;
            lc_addr_in  = PA'($urandom);
            if (lq_due.size() > 0) begin
                if (cyc >= lq_due[0]) begin
                    lc_valid_in = 1'b1;
                    lc_addr_in  = lq_addr[0];
                end
            end
            lc_value_in = rand_line();
            #1;
            if (req_ready_out !== '0) begin
                n_tests++;
                if (req_ready_out !== oh(n_gnt % 2)) begin
                    n_fail++; $display("FAIL fair_grant%0d: got %b expected %b", n_gnt, req_ready_out, oh(n_gnt % 2));
                end
                pend_addr = r_addr[n_gnt % 2];
                n_gnt++;
            end
            if (lc_valid_out && lc_ready_in) begin
                n_tests++;
                if (lc_addr_out !== pend_addr) begin
                    n_fail++; $display("FAIL fair_lc_addr: got %h expected %h", lc_addr_out, pend_addr);
                end
                lq_addr.push_back(pend_addr);
                lq_due.push_back(cyc + 3);
            end
            if (lc_valid_in) begin
                n_tests++;
                if (rsp_valid_out !== oh(n_rsp % 2) || lc_ready_out !== 1'b1 || rsp_addr_out !== lq_addr[0]) begin
                    n_fail++; $display("FAIL fair_rsp%0d: rsp_valid=%b lc_ready=%b addr=%h expected %b 1 %h",
                                       n_rsp, rsp_valid_out, lc_ready_out, rsp_addr_out, oh(n_rsp % 2), lq_addr[0]);
                end
                void'(lq_addr.pop_front());
                void'(lq_due.pop_front());
                n_rsp++;
            end
        end
        n_tests++;
        if (n_rsp != 4 || n_gnt != 4) begin
            n_fail++; $display("FAIL fair_count: grants=%0d responses=%0d expected 4 4", n_gnt, n_rsp);
        end
    endtask

    task automatic test_backpressure();
        logic [LW-1:0] v1;
        v1 = rand_line();
        do_reset();
        rsp_ready_in = '1;
        @(negedge clk_in);
        r_valid[1] = 1'b1; r_addr[1] = 19'h1A40; r_we[1] = 1'b1; r_val[1] = v1;
        #1;
        n_tests++;
        if (req_ready_out !== 2'b10) begin
            n_fail++; $display("FAIL bp_grant: got %b expected 10", req_ready_out);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            for (int j = 0; j < int'(NR); j++) begin
                r_valid[j] = 1'b1; r_we[j] = 1'b0;
                r_addr[j] = PA'($urandom); r_val[j] = rand_line();
            end
            lc_ready_in = (i == 5);
            #1;
            n_tests++;
            if (lc_valid_out !== 1'b1 || lc_addr_out !== 19'h1A40 || lc_we_out !== 1'b1 || lc_value_out !== v1) begin
                n_fail++; $display("FAIL bp_hold%0d: valid=%b addr=%h we=%b expected 1 01a40 1 (value match=%b)",
                                   i, lc_valid_out, lc_addr_out, lc_we_out, lc_value_out === v1);
            end
            n_tests++;
            if (req_ready_out !== 2'b00) begin
                n_fail++; $display("FAIL bp_ready%0d: got %b expected 00", i, req_ready_out);
            end
        end
        @(negedge clk_in);
        lc_ready_in = 1'b0;
        #1;
        n_tests++;
        if (lc_valid_out !== 1'b0 || req_ready_out !== 2'b01) begin
            n_fail++; $display("FAIL bp_rr: lc_valid=%b req_ready=%b expected 0 01", lc_valid_out, req_ready_out);
        end
    endtask

    task automatic test_full_fifo();
        int got;
        got = 0;
        do_reset();
        rsp_ready_in = '1;
        lc_ready_in  = 1'b1;
        for (int c = 0; c < 20 && got < 4; c++) begin
            @(negedge clk_in);
            r_valid[0] = 1'b1; r_we[0] = 1'b0; r_addr[0] = PA'($urandom);
            #1;
            if (req_ready_out === 2'b01) got++;
        end
        n_tests++;
        if (got != 4) begin
            n_fail++; $display("FAIL full_issue: grants=%0d expected 4", got);
        end
        for (int c = 0; c < 6; c++) begin
            @(negedge clk_in); #1;
            n_tests++;
            if (req_ready_out !== 2'b00 || (c > 0 && lc_valid_out !== 1'b0)) begin
                n_fail++; $display("FAIL full_block%0d: req_ready=%b lc_valid=%b expected 00 0", c, req_ready_out, lc_valid_out);
            end
        end
        @(negedge clk_in);
        lc_valid_in = 1'b1; lc_addr_in = PA'($urandom);
        #1;
        n_tests++;
        if (lc_ready_out !== 1'b1 || rsp_valid_out !== 2'b01 || req_ready_out !== 2'b00) begin
            n_fail++; $display("FAIL full_pop: lc_ready=%b rsp_valid=%b req_ready=%b expected 1 01 00",
                               lc_ready_out, rsp_valid_out, req_ready_out);
        end
        @(negedge clk_in);
        lc_valid_in = 1'b0;
        #1;
        n_tests++;
        if (req_ready_out !== 2'b01) begin
            n_fail++; $display("FAIL full_regrant: got %b expected 01", req_ready_out);
        end
    endtask

    task automatic test_rsp_stall();
        int            order [3] = '{1, 0, 1};
        logic [PA-1:0] a;
        do_reset();
        rsp_ready_in = '1;
        lc_ready_in  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            r_valid[order[k]] = 1'b1; r_addr[order[k]] = PA'($urandom);
            #1;
            n_tests++;
            if (req_ready_out !== oh(order[k])) begin
                n_fail++; $display("FAIL stall_issue%0d: got %b expected %b", k, req_ready_out, oh(order[k]));
            end
            @(negedge clk_in);
            r_valid[0] = 1'b0; r_valid[1] = 1'b0;
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_in);
            rsp_ready_in = 2'b01; lc_valid_in = 1'b1; lc_addr_in = PA'($urandom);
            #1;
            n_tests++;
            if (lc_ready_out !== 1'b0 || rsp_valid_out !== 2'b10) begin
                n_fail++; $display("FAIL stall_hold%0d: lc_ready=%b rsp_valid=%b expected 0 10", c, lc_ready_out, rsp_valid_out);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            a = PA'($urandom);
            rsp_ready_in = 2'b11; lc_valid_in = 1'b1; lc_addr_in = a; lc_value_in = rand_line();
            #1;
            n_tests++;
            if (rsp_valid_out !== oh(order[k]) || lc_ready_out !== 1'b1 ||
                rsp_addr_out !== a || rsp_value_out !== lc_value_in) begin
                n_fail++; $display("FAIL stall_route%0d: rsp_valid=%b lc_ready=%b addr=%h expected %b 1 %h",
                                   k, rsp_valid_out, lc_ready_out, rsp_addr_out, oh(order[k]), a);
            end
        end
        @(negedge clk_in);
        lc_valid_in = 1'b0;
        #1;
        n_tests++;
        if (lc_ready_out !== 1'b0 || err_unexpected_rsp_out !== 1'b0) begin
            n_fail++; $display("FAIL stall_empty: lc_ready=%b err=%b expected 0 0", lc_ready_out, err_unexpected_rsp_out);
        end
    endtask

    task automatic test_unexpected();
        do_reset();
        @(negedge clk_in);
        rsp_ready_in = '1; lc_valid_in = 1'b1; lc_addr_in = PA'($urandom);
        #1;
        n_tests++;
        if (lc_ready_out !== 1'b0 || rsp_valid_out !== 2'b00 || err_unexpected_rsp_out !== 1'b0) begin
            n_fail++; $display("FAIL unexp_first: lc_ready=%b rsp_valid=%b err=%b expected 0 00 0",
                               lc_ready_out, rsp_valid_out, err_unexpected_rsp_out);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_in);
            lc_valid_in = 1'b0;
            #1;
            n_tests++;
            if (err_unexpected_rsp_out !== 1'b1) begin
                n_fail++; $display("FAIL unexp_sticky%0d: err=%b expected 1", c, err_unexpected_rsp_out);
            end
        end
        @(negedge clk_in);
        rst_N_in = 1'b0;
        #1;
        n_tests++;
        if (err_unexpected_rsp_out !== 1'b0) begin
            n_fail++; $display("FAIL unexp_clear: err=%b expected 0", err_unexpected_rsp_out);
        end
        @(negedge clk_in);
        rst_N_in = 1'b1;
    endtask

    task automatic test_reset_mid_hold();
        int order [3] = '{1, 0, 1};
        do_reset();
        rsp_ready_in = '1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_in);
            lc_ready_in = (k < 2);
            r_valid[order[k]] = 1'b1;
            #1;
            n_tests++;
            if (req_ready_out !== oh(order[k])) begin
                n_fail++; $display("FAIL mh_issue%0d: got %b expected %b", k, req_ready_out, oh(order[k]));
            end
            @(negedge clk_in);
            r_valid[0] = 1'b0; r_valid[1] = 1'b0;
        end
        #1;
        n_tests++;
        if (lc_valid_out !== 1'b1) begin
            n_fail++; $display("FAIL mh_hold: lc_valid=%b expected 1", lc_valid_out);
        end
        #2;
        rst_N_in = 1'b0;
        cs_N_in  = 1'b1;
        #1;
        n_tests++;
        if (lc_valid_out !== 1'b0) begin
            n_fail++; $display("FAIL mh_async: lc_valid=%b expected 0", lc_valid_out);
        end
        @(negedge clk_in);
        @(negedge clk_in);
        rst_N_in = 1'b1;
        r_valid[0] = 1'b1; r_valid[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_in); #1;
            n_tests++;
            if (req_ready_out !== 2'b00 || lc_valid_out !== 1'b0) begin
                n_fail++; $display("FAIL mh_cs_block%0d: req_ready=%b lc_valid=%b expected 00 0", c, req_ready_out, lc_valid_out);
            end
        end
        @(negedge clk_in);
        cs_N_in = 1'b0;
        #1;
        n_tests++;
        if (req_ready_out !== 2'b01) begin
            n_fail++; $display("FAIL mh_resume: got %b expected 01", req_ready_out);
        end
        @(negedge clk_in);
        r_valid[0] = 1'b0; r_valid[1] = 1'b0; lc_ready_in = 1'b1;
        @(negedge clk_in);
        lc_valid_in = 1'b1; lc_addr_in = PA'($urandom);
        #1;
        n_tests++;
        if (rsp_valid_out !== 2'b01 || lc_ready_out !== 1'b1) begin
            n_fail++; $display("FAIL mh_route: rsp_valid=%b lc_ready=%b expected 01 1", rsp_valid_out, lc_ready_out);
        end
        @(negedge clk_in);
        lc_valid_in = 1'b0;
    endtask

    task automatic test_random();
        int            q[$];
        logic [PA-1:0] llc_a[$];
        logic [LW-1:0] llc_d[$];
        logic          m_hold, m_we, m_err, e_lcr;
        int            m_own, m_next, g, idx;
        logic [PA-1:0] m_addr;
        logic [LW-1:0] m_val;
        logic [NR-1:0] e_rdy, e_rsp;
        m_hold = 1'b0; m_we = 1'b0; m_err = 1'b0; m_own = 0; m_next = 0;
        m_addr = '0; m_val = '0;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk_in);
            cs_N_in = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < int'(NR); i++) begin
                r_valid[i] = ($urandom_range(0, 2) != 0);
                r_we[i]    = 1'($urandom());
                r_addr[i]  = PA'($urandom());
                r_val[i]   = rand_line();
            end
            rsp_ready_in = NR'($urandom_range(0, 3));
            lc_ready_in  = ($urandom_range(0, 2) != 0);
            lc_valid_in  = (llc_a.size() > 0) && ($urandom_range(0, 1) == 1);
            lc_addr_in   = lc_valid_in ? llc_a[0] : PA'($urandom());
            lc_value_in  = lc_valid_in ? llc_d[0] : rand_line();
            #1;
            g = -1;
            if (!m_hold && !cs_N_in && q.size() < int'(MO)) begin
                for (int k = 0; k < int'(NR); k++) begin
                    idx = (m_next + k) % int'(NR);
                    if (g < 0 && r_valid[idx]) g = idx;
                end
            end
            e_rdy = (g >= 0) ? oh(g) : '0;
            e_rsp = (lc_valid_in && q.size() > 0) ? oh(q[0]) : '0;
            e_lcr = (q.size() > 0) ? rsp_ready_in[IW'(q[0])] : 1'b0;
            n_tests++;
            if (req_ready_out !== e_rdy) begin
                n_fail++; $display("FAIL rnd_req_ready c%0d: got %b expected %b", c, req_ready_out, e_rdy);
            end
            n_tests++;
            if (rsp_valid_out !== e_rsp || lc_ready_out !== e_lcr) begin
                n_fail++; $display("FAIL rnd_rsp c%0d: rsp_valid=%b lc_ready=%b expected %b %b",
                                   c, rsp_valid_out, lc_ready_out, e_rsp, e_lcr);
            end
            n_tests++;
            if (lc_valid_out !== m_hold) begin
                n_fail++; $display("FAIL rnd_lc_valid c%0d: got %b expected %b", c, lc_valid_out, m_hold);
            end
            if (m_hold) begin
                n_tests++;
                if (lc_addr_out !== m_addr || lc_we_out !== m_we || lc_value_out !== m_val) begin
                    n_fail++; $display("FAIL rnd_lc_payload c%0d: addr=%h we=%b expected %h %b (value match=%b)",
                                       c, lc_addr_out, lc_we_out, m_addr, m_we, lc_value_out === m_val);
                end
            end
            n_tests++;
            if (rsp_addr_out !== lc_addr_in || rsp_value_out !== lc_value_in || err_unexpected_rsp_out !== m_err) begin
                n_fail++; $display("FAIL rnd_pass c%0d: rsp_addr=%h err=%b expected %h %b",
                                   c, rsp_addr_out, err_unexpected_rsp_out, lc_addr_in, m_err);
            end
            if (lc_valid_in && q.size() == 0) m_err = 1'b1;
            if (lc_valid_in && e_lcr) begin
                void'(q.pop_front());
                void'(llc_a.pop_front());
                void'(llc_d.pop_front());
            end
            if (g >= 0) begin
                q.push_back(g);
                m_hold = 1'b1; m_own = g;
                m_addr = r_addr[g]; m_val = r_val[g]; m_we = r_we[g];
            end else if (m_hold && lc_ready_in) begin
                m_hold = 1'b0;
                m_next = (m_own + 1) % int'(NR);
                llc_a.push_back(m_addr);
                llc_d.push_back(rand_line());
            end
        end
    endtask

    initial begin
        rst_N_in = 1'b0;
        idle_inputs();
        test_reset();
        test_fairness();
        test_backpressure();
        test_full_fifo();
        test_rsp_stall();
        test_unexpected();
        test_reset_mid_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
